// File: rtl/tsc_pkg.sv
// Shared definitions for the TSC dump reader: FSM encoding, default sizes, serial idle level.
package tsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_DONE
  } tsc_state_e;

  localparam int NBYTES_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam logic SD_IDLE   = 1'b0;

endpackage

// File: rtl/sd_deser.sv
// Serial-to-byte deserialiser: MSB-first shift, saturating bit count, byte strobe on every 8th bit.
module sd_deser
  import tsc_pkg::*;
#(
  parameter int NBITS = NBYTES_DEF * 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    shift_en,
  input  logic                    sd,
  output logic [$clog2(NBITS):0]  bit_cnt,
  output logic [7:0]              byte_data,
  output logic                    byte_valid
);

  localparam int CW = $clog2(NBITS) + 1;

  // Only seven bits are stored; the eighth is the live sd bit on the completing edge.
  logic [6:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active;

  always_comb begin
    active  = shift_en && (cnt_q != CW'(NBITS));
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (active) begin
      shift_d = {shift_q[5:0], sd};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= {7{SD_IDLE}};
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_data  = {shift_q, sd};
  assign byte_valid = active && (cnt_q[2:0] == 3'b111);
  assign bit_cnt    = cnt_q;

endmodule

// File: rtl/tsc_reader.sv
// Trigger-driven dump reader: requests the TSC sample buffer, deserialises it and exposes it to the host.
module tsc_reader
  import tsc_pkg::*;
#(
  parameter int NBYTES  = NBYTES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trd,
  input  logic                      sd,
  input  logic [31:0]               trigtm,
  output logic                      sbf,
  input  logic [$clog2(NBYTES)-1:0] rd_addr,
  output logic [7:0]                rd_data,
  output logic [31:0]               trig_time,
  output logic                      done,
  output logic                      err,
  output logic                      busy
);

  localparam int NBITS = NBYTES * 8;
  localparam int CW    = $clog2(NBITS) + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int AW    = $clog2(NBYTES);

  tsc_state_e    state_q, state_d;
  logic          sbf_q, sbf_d;
  logic          err_q, err_d;
  logic          armed_q, armed_d;
  logic [31:0]   trig_q, trig_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          clr, shift_en, byte_valid;
  logic [7:0]    byte_data;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    buf_mem [NBYTES];

  sd_deser #(.NBITS(NBITS)) u_deser (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .shift_en  (shift_en),
    .sd        (sd),
    .bit_cnt   (bit_cnt),
    .byte_data (byte_data),
    .byte_valid(byte_valid)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    armed_d  = armed_q;
    trig_d   = trig_q;
    tmo_d    = tmo_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    // Any cycle with trd low re-arms; the start edge below always has trd high.
    if (!trd) armed_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (trd && armed_q) begin
          state_d = ST_REQ;
          trig_d  = trigtm;
          err_d   = 1'b0;
          armed_d = 1'b0;
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        if (!trd) begin
          state_d = ST_IDLE;
        end else if (sd != SD_IDLE) begin
          state_d = ST_RECV;
          clr     = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RECV: begin
        if (!trd) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == CW'(NBITS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    sbf_d = (state_d == ST_REQ) || (state_d == ST_RECV);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sbf_q   <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
      trig_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sbf_q   <= sbf_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      trig_q  <= trig_d;
      tmo_q   <= tmo_d;
    end
  end

  // Capture buffer survives reset so the host can still read a partial dump.
  always_ff @(posedge clk) begin
    if (byte_valid) buf_mem[bit_cnt[CW-2:3]] <= byte_data;
  end

  generate
    if (NBYTES == (1 << AW)) begin : g_pow2
      assign rd_data = buf_mem[rd_addr];
    end else begin : g_npow2
      assign rd_data = (32'(rd_addr) < NBYTES) ? buf_mem[rd_addr] : 8'h00;
    end
  endgenerate

  assign sbf       = sbf_q;
  assign err       = err_q;
  assign trig_time = trig_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tsc_reader.sv
// Directed bench for tsc_reader: full dumps, timeout, trd abort, re-arm, async reset and clock stop.
module tb_tsc_reader;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset;
  logic        trd;
  logic        sd;
  logic [31:0] trigtm;
  logic        sbf;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [31:0] trig_time;
  logic        done;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int sbf_n, done_n;

  tsc_reader #(.NBYTES(32), .TIMEOUT(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .trd      (trd),
    .sd       (sd),
    .trigtm   (trigtm),
    .sbf      (sbf),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .trig_time(trig_time),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected byte k of a dump is k ^ xv.
  task automatic chk_buf(input string tag, input logic [7:0] xv, input int lo, input int hi);
    logic [7:0] e;
    for (int k = lo; k <= hi; k++) begin
      rd_addr = 5'(k);
      #1;
      e = 8'(k) ^ xv;
      chk($sformatf("%s[%0d]", tag, k), {24'h0, rd_data}, {24'h0, e});
    end
  endtask

  // One dump: trd low one cycle, then high; 'lead' idle REQ cycles before the start bit, then 256 data bits.
  // abort/rst/stop give the data-bit index at which trd drops, reset hits, or the clock halts (-1 = never).
  task automatic run_dump(input int lead, input logic [7:0] xv, input logic [31:0] tm,
                          input int abort_at, input int rst_at, input int stop_at,
                          output int s_n, output int d_n);
    logic [7:0] b;
    int j;
    s_n = 0;
    d_n = 0;
    @(negedge clk);
    trd = 1'b0;
    sd  = 1'b0;
    @(negedge clk);
    trd    = 1'b1;
    trigtm = tm;
    for (int i = 1; i <= lead + 262; i++) begin
      @(negedge clk);
      if (sbf)  s_n++;
      if (done) d_n++;
      j = i - lead - 2;
      if (i == lead + 1) sd = 1'b1;
      else if (j >= 0 && j < 256) begin
        b  = 8'(j / 8) ^ xv;
        sd = b[7 - (j % 8)];
      end else sd = 1'b0;
      if (abort_at >= 0 && j == abort_at) trd = 1'b0;
      if (stop_at >= 0 && j == stop_at) begin
        clk_en = 1'b0;
        #92;
        chk("stop_busy", {31'h0, busy}, 32'h1);
        chk("stop_sbf",  {31'h0, sbf},  32'h1);
        chk("stop_done", {31'h0, done}, 32'h0);
        clk_en = 1'b1;
      end
      if (rst_at >= 0 && j == rst_at) begin
        #2;
        reset = 1'b0;
        trd   = 1'b0;
        #1;
        chk("rst_sbf",   {31'h0, sbf},  32'h0);
        chk("rst_busy",  {31'h0, busy}, 32'h0);
        chk("rst_done",  {31'h0, done}, 32'h0);
        chk("rst_err",   {31'h0, err},  32'h0);
        chk("rst_trig",  trig_time,     32'h0);
        @(negedge clk);
        reset = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    trd     = 1'b0;
    sd      = 1'b0;
    trigtm  = 32'h0;
    rd_addr = 5'd0;
    #23;
    chk("reset_sbf",  {31'h0, sbf},  32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_err",  {31'h0, err},  32'h0);
    chk("reset_trig", trig_time,     32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Basic dump: start bit after 3 idle cycles, bytes 0x00..0x1F.
    run_dump(3, 8'h00, 32'd37, -1, -1, -1, sbf_n, done_n);
    chk("A_sbf_cycles", sbf_n, 32'd260);
    chk("A_done_cnt", done_n, 32'd1);
    chk("A_trig", trig_time, 32'd37);
    chk("A_err", {31'h0, err}, 32'h0);
    chk("A_busy", {31'h0, busy}, 32'h0);
    $display("dump A: sbf_cycles=%0d done=%0d", sbf_n, done_n);
    chk_buf("A_buf", 8'h00, 0, 31);

    // trd held high after completion: no new request.
    sbf_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sbf) sbf_n++;
    end
    chk("rearm_sbf", sbf_n, 32'd0);
    chk("rearm_busy", {31'h0, busy}, 32'h0);

    // Second dump overwrites the buffer; start bit seen on the first REQ edge.
    run_dump(0, 8'hA5, 32'hDEADBEEF, -1, -1, -1, sbf_n, done_n);
    chk("B_sbf_cycles", sbf_n, 32'd257);
    chk("B_done_cnt", done_n, 32'd1);
    chk("B_trig", trig_time, 32'hDEADBEEF);
    $display("dump B: sbf_cycles=%0d done=%0d", sbf_n, done_n);
    chk_buf("B_buf", 8'hA5, 0, 31);

    // trd drops after 100 data bits.
    run_dump(2, 8'h3C, 32'h11, 100, -1, -1, sbf_n, done_n);
    chk("abort_sbf_cycles", sbf_n, 32'd104);
    chk("abort_done_cnt", done_n, 32'd0);
    chk("abort_err", {31'h0, err}, 32'h1);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    $display("abort: sbf_cycles=%0d done=%0d err=%0b", sbf_n, done_n, err);
    chk_buf("abort_new", 8'h3C, 0, 11);
    chk_buf("abort_old", 8'hA5, 12, 12);
    chk_buf("abort_tail", 8'hA5, 31, 31);

    // No start bit: timeout after 64 REQ cycles.
    run_dump(70, 8'h00, 32'h22, -1, -1, -1, sbf_n, done_n);
    chk("tmo_sbf_cycles", sbf_n, 32'd64);
    chk("tmo_done_cnt", done_n, 32'd0);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_busy", {31'h0, busy}, 32'h0);
    chk("tmo_trig", trig_time, 32'h22);
    $display("timeout: sbf_cycles=%0d err=%0b", sbf_n, err);

    // Asynchronous reset in the middle of RECV, then a clean dump.
    run_dump(1, 8'h77, 32'h33, -1, 40, -1, sbf_n, done_n);
    chk("rst_done_cnt", done_n, 32'd0);
    run_dump(1, 8'h5A, 32'h44, -1, -1, -1, sbf_n, done_n);
    chk("C_sbf_cycles", sbf_n, 32'd258);
    chk("C_done_cnt", done_n, 32'd1);
    chk("C_err", {31'h0, err}, 32'h0);
    $display("dump C after reset: sbf_cycles=%0d done=%0d", sbf_n, done_n);
    chk_buf("C_buf", 8'h5A, 0, 31);

    // Clock halted for 9 cycles mid-RECV.
    run_dump(3, 8'hC3, 32'h55, -1, -1, 50, sbf_n, done_n);
    chk("D_sbf_cycles", sbf_n, 32'd260);
    chk("D_done_cnt", done_n, 32'd1);
    chk("D_err", {31'h0, err}, 32'h0);
    $display("dump D clock stop: sbf_cycles=%0d done=%0d", sbf_n, done_n);
    chk_buf("D_buf", 8'hC3, 0, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tsc_reader.md
TSC_READER -- requirements
Module: tsc_reader

Interface
REQ-001 Parameter NBYTES, default 32, number of sample bytes per dump.
REQ-002 Parameter TIMEOUT, default 64, maximum clk cycles from sbf rise to start bit.
REQ-003 Port clk  input  1  single clock for the block; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port trd  input  1  trigger-detected flag from the TSC; buffer ready for dump.
REQ-006 Port sd  input  1  serial data from the TSC; idles low.
REQ-007 Port trigtm  input  32  trigger timestamp from the TSC.
REQ-008 Port sbf  output  1  send-buffer request to the TSC.
REQ-009 Port rd_addr  input  log2(NBYTES)  host read address into the captured buffer.
REQ-010 Port rd_data  output  8  byte at rd_addr; combinational read.
REQ-011 Port trig_time  output  32  trigtm latched at dump start.
REQ-012 Port done  output  1  one-cycle pulse when a dump completes without error.
REQ-013 Port err  output  1  sticky error flag; cleared at the next dump start or reset.
REQ-014 Port busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, REQ, RECV, DONE.
REQ-016 IDLE->REQ on the first clk edge where trd=1 and no dump has been taken for the current trd assertion; same edge latches trigtm into trig_time and clears err.
REQ-017 sbf is registered: 1 in REQ and RECV, 0 in all other states.
REQ-018 REQ waits for a start bit (sd=1); the edge that samples it moves to RECV and clears the bit counter.
REQ-019 REQ with TIMEOUT cycles elapsed and no start bit -> IDLE, err=1.
REQ-020 REQ with trd falling before the start bit -> IDLE, err unchanged, no dump.
REQ-021 RECV shifts one sd bit per clk, MSB first; every 8th bit writes the assembled byte to buffer[byte_index], byte_index 0..NBYTES-1.
REQ-022 After exactly NBYTES*8 data bits: RECV->DONE; sbf drops on that edge.
REQ-023 trd falling during RECV -> IDLE, err=1; bytes already written stay in the buffer, remainder unchanged.
REQ-024 DONE lasts one cycle with done=1, then -> IDLE.
REQ-025 The block takes no new dump until trd has been seen low for at least one cycle since the last dump start (re-arm rule).
REQ-026 Bit counter width is log2(NBYTES*8)+1; it saturates and never wraps within a dump.
REQ-027 rd_data reflects buffer writes from the cycle after the write edge; rd_addr values >= NBYTES return 8'h00.
REQ-028 No clock means no state change; operation resumes from the held state when the clock restarts.

Reset
REQ-029 reset=0 immediately forces state IDLE, sbf=0, done=0, err=0, busy=0, trig_time=0, counters=0, re-arm=1, regardless of clk.
REQ-030 Buffer contents are not cleared by reset.
REQ-031 Reset asserted mid-RECV aborts the dump with no done pulse; after release, the block follows REQ-016 and REQ-025.

Structure
REQ-032 Shared package tsc_pkg holds the state encoding, the NBYTES/TIMEOUT defaults and the sd idle level.
REQ-033 Sub-module sd_deser (8-bit shift register, bit count, byte_valid strobe) is instantiated once; the FSM, timeout counter and buffer live in tsc_reader.

Verification
REQ-034 trd=1, trigtm=32'd37, start bit after 3 cycles, 256 bits encoding bytes 0x00..0x1F -> sbf high for 260 cycles, done pulse once, rd_data[k]=k, trig_time=37, err=0.
REQ-035 trd=1, sd held 0 -> sbf falls after 64 cycles, err=1, done never asserts, busy=0.
REQ-036 trd falls after 100 data bits -> next edge IDLE, err=1, bytes 0..11 valid, byte 12 unchanged.
REQ-037 trd held high after a completed dump -> no second sbf until trd goes 0 then 1; the second dump overwrites the buffer.
REQ-038 reset=0 asserted mid-RECV between clock edges -> sbf=0 and busy=0 immediately, no done; after release, a full dump completes normally.
REQ-039 Clock stopped 9 cycles during RECV -> no state change while stopped; after restart the dump completes with correct data.
